// File: rtl/sync_code_tracker_pkg.sv
// Shared definitions for the sync code tracker: sync_type encoding,
// default code nibbles and the preamble detector state encoding.
package sync_code_pkg;

  // sync_type output encoding
  localparam logic [1:0] SYNC_SOF = 2'd0;
  localparam logic [1:0] SYNC_SOL = 2'd1;
  localparam logic [1:0] SYNC_EOL = 2'd2;
  localparam logic [1:0] SYNC_EOF = 2'd3;

  // Default code nibbles (top nibble of the code word)
  localparam logic [3:0] DEF_SOF_CODE = 4'hA;
  localparam logic [3:0] DEF_SOL_CODE = 4'h8;
  localparam logic [3:0] DEF_EOL_CODE = 4'h9;
  localparam logic [3:0] DEF_EOF_CODE = 4'hB;

  // Width of the all-zero word counter (NZERO is at most 15)
  localparam int ZCNT_W = 4;

  // Preamble detector states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONES  = 2'd1,
    ZEROS = 2'd2,
    CODE  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_code_tracker_if.sv
// Data and status bundle between the capture register side (master)
// and the sync code tracker (slave).
interface sync_code_tracker_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
) ();
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              toggle_out;
  logic              sync_valid;
  logic [1:0]        sync_type;
  logic              frame_active;
  logic              line_active;
  logic [CNT_W-1:0]  line_len;
  logic [CNT_W-1:0]  line_count;
  logic              code_err;
  logic              proto_err;

  modport master (
    output data_in, in_valid,
    input  toggle_out, sync_valid, sync_type, frame_active, line_active,
           line_len, line_count, code_err, proto_err
  );

  modport slave (
    input  data_in, in_valid,
    output toggle_out, sync_valid, sync_type, frame_active, line_active,
           line_len, line_count, code_err, proto_err
  );
endinterface

// File: rtl/sync_code_tracker_preamble_fsm.sv
// Preamble detector: one all-ones word, NZERO all-zero words, then the
// code word. Flags the code word cycle and exposes its top nibble.
module preamble_fsm
  import sync_code_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int NZERO  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_code_strobe,
  output logic [3:0]        o_nibble
);

  state_e              r_state;
  state_e              w_state_nx;
  logic [ZCNT_W-1:0]   r_zcnt;
  logic [ZCNT_W-1:0]   w_zcnt_nx;
  logic                w_ones;
  logic                w_zeros;

  assign w_ones        = &i_data;
  assign w_zeros       = ~|i_data;
  assign o_code_strobe = i_valid && (r_state == CODE);
  assign o_nibble      = i_data[DATA_W-1 -: 4];

  // State and zero-count registers; advance only on valid words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_zcnt  <= '0;
    end else if (i_valid) begin
      r_state <= w_state_nx;
      r_zcnt  <= w_zcnt_nx;
    end else begin
      r_state <= r_state;
      r_zcnt  <= r_zcnt;
    end
  end

  // Next-state logic; any all-ones word always (re)starts the preamble
  always_comb begin
    w_state_nx = r_state;
    w_zcnt_nx  = r_zcnt;
    case (r_state)
      IDLE: begin
        w_zcnt_nx = {ZCNT_W{1'b0}};
        if (w_ones) w_state_nx = ONES;
        else        w_state_nx = IDLE;
      end
      ONES: begin
        if (w_zeros) begin
          if (NZERO == 1) begin
            w_state_nx = CODE;
            w_zcnt_nx  = {ZCNT_W{1'b0}};
          end else begin
            w_state_nx = ZEROS;
            w_zcnt_nx  = ZCNT_W'(1);
          end
        end else if (w_ones) begin
          w_state_nx = ONES;
          w_zcnt_nx  = {ZCNT_W{1'b0}};
        end else begin
          w_state_nx = IDLE;
          w_zcnt_nx  = {ZCNT_W{1'b0}};
        end
      end
      ZEROS: begin
        if (w_zeros) begin
          if ((r_zcnt + ZCNT_W'(1)) == ZCNT_W'(NZERO)) begin
            w_state_nx = CODE;
            w_zcnt_nx  = {ZCNT_W{1'b0}};
          end else begin
            w_state_nx = ZEROS;
            w_zcnt_nx  = r_zcnt + ZCNT_W'(1);
          end
        end else if (w_ones) begin
          w_state_nx = ONES;
          w_zcnt_nx  = {ZCNT_W{1'b0}};
        end else begin
          w_state_nx = IDLE;
          w_zcnt_nx  = {ZCNT_W{1'b0}};
        end
      end
      CODE: begin
        w_zcnt_nx = {ZCNT_W{1'b0}};
        if (w_ones) w_state_nx = ONES;
        else        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_zcnt_nx  = {ZCNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/sync_code_tracker.sv
// Sync code tracker: decodes SOF/SOL/EOL/EOF after the preamble, tracks
// frame/line state, line length and line count, and flags errors.
module sync_code_tracker
  import sync_code_pkg::*;
#(
  parameter int         DATA_W   = 12,
  parameter int         NZERO    = 2,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] SOF_CODE = DEF_SOF_CODE,
  parameter logic [3:0] SOL_CODE = DEF_SOL_CODE,
  parameter logic [3:0] EOL_CODE = DEF_EOL_CODE,
  parameter logic [3:0] EOF_CODE = DEF_EOF_CODE
) (
  input logic               clk,
  input logic               rst_n,
  sync_code_tracker_if.slave bus
);

  // Words counted on a line include the EOL preamble (ones + zeros)
  localparam logic [CNT_W-1:0] PRE_LEN = CNT_W'(NZERO + 1);

  logic             w_code_strobe;
  logic [3:0]       w_nibble;
  logic             w_known;
  logic [1:0]       w_type;

  logic             r_toggle,     w_toggle_nx;
  logic             r_sync_valid, w_sync_valid_nx;
  logic [1:0]       r_type,       w_type_nx;
  logic             r_frame,      w_frame_nx;
  logic             r_line,       w_line_nx;
  logic [CNT_W-1:0] r_len,        w_len_nx;
  logic [CNT_W-1:0] r_count,      w_count_nx;
  logic [CNT_W-1:0] r_wcnt,       w_wcnt_nx;
  logic             r_code_err,   w_code_err_nx;
  logic             r_proto_err,  w_proto_err_nx;

  preamble_fsm #(
    .DATA_W (DATA_W),
    .NZERO  (NZERO)
  ) u_preamble (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_data        (bus.data_in),
    .i_valid       (bus.in_valid),
    .o_code_strobe (w_code_strobe),
    .o_nibble      (w_nibble)
  );

  // Map the code nibble onto a sync_type; unknown nibbles are flagged
  always_comb begin
    w_known = 1'b1;
    w_type  = SYNC_SOF;
    case (w_nibble)
      SOF_CODE: w_type = SYNC_SOF;
      SOL_CODE: w_type = SYNC_SOL;
      EOL_CODE: w_type = SYNC_EOL;
      EOF_CODE: w_type = SYNC_EOF;
      default:  w_known = 1'b0;
    endcase
  end

  // Frame/line tracking; everything holds unless a valid word arrives
  always_comb begin
    w_toggle_nx     = r_toggle;
    w_sync_valid_nx = 1'b0;
    w_type_nx       = r_type;
    w_frame_nx      = r_frame;
    w_line_nx       = r_line;
    w_len_nx        = r_len;
    w_count_nx      = r_count;
    w_wcnt_nx       = r_wcnt;
    w_code_err_nx   = 1'b0;
    w_proto_err_nx  = 1'b0;
    if (w_code_strobe) begin
      if (w_known) begin
        w_sync_valid_nx = 1'b1;
        w_type_nx       = w_type;
        w_toggle_nx     = ~r_toggle;
        case (w_type)
          SYNC_SOL: begin
            // A SOL inside a line restarts the line
            w_proto_err_nx = r_line;
            w_line_nx      = 1'b1;
            w_wcnt_nx      = {CNT_W{1'b0}};
          end
          SYNC_EOL: begin
            if (r_line) begin
              w_len_nx   = (r_wcnt > PRE_LEN) ? (r_wcnt - PRE_LEN) : {CNT_W{1'b0}};
              w_count_nx = (&r_count) ? r_count : (r_count + CNT_W'(1));
              w_line_nx  = 1'b0;
            end else begin
              w_proto_err_nx = 1'b1;
            end
          end
          SYNC_SOF: begin
            w_proto_err_nx = r_frame;
            w_frame_nx     = 1'b1;
            w_count_nx     = {CNT_W{1'b0}};
            w_line_nx      = 1'b0;
          end
          SYNC_EOF: begin
            if (!r_frame) begin
              w_proto_err_nx = 1'b1;
            end else if (r_line) begin
              w_proto_err_nx = 1'b1;
              w_frame_nx     = 1'b0;
              w_line_nx      = 1'b0;
            end else begin
              w_frame_nx = 1'b0;
            end
          end
          default: begin
            w_type_nx = r_type;
          end
        endcase
      end else begin
        w_code_err_nx = 1'b1;
      end
    end else if (bus.in_valid && r_line) begin
      w_wcnt_nx = (&r_wcnt) ? r_wcnt : (r_wcnt + CNT_W'(1));
    end else begin
      w_wcnt_nx = r_wcnt;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_toggle     <= 1'b0;
      r_sync_valid <= 1'b0;
      r_type       <= SYNC_SOF;
      r_frame      <= 1'b0;
      r_line       <= 1'b0;
      r_len        <= {CNT_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_wcnt       <= {CNT_W{1'b0}};
      r_code_err   <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_toggle     <= w_toggle_nx;
      r_sync_valid <= w_sync_valid_nx;
      r_type       <= w_type_nx;
      r_frame      <= w_frame_nx;
      r_line       <= w_line_nx;
      r_len        <= w_len_nx;
      r_count      <= w_count_nx;
      r_wcnt       <= w_wcnt_nx;
      r_code_err   <= w_code_err_nx;
      r_proto_err  <= w_proto_err_nx;
    end
  end

  assign bus.toggle_out   = r_toggle;
  assign bus.sync_valid   = r_sync_valid;
  assign bus.sync_type    = r_type;
  assign bus.frame_active = r_frame;
  assign bus.line_active  = r_line;
  assign bus.line_len     = r_len;
  assign bus.line_count   = r_count;
  assign bus.code_err     = r_code_err;
  assign bus.proto_err    = r_proto_err;

endmodule

// File: doc/sync_code_tracker.md
Name: sync_code_tracker

Overview:
- Parametrised successor to the 12-bit FFF-000-000 toggle detector.
- Detects a sensor sync preamble: one all-ones word, then NZERO all-zero words, then one sync code word.
- Decodes SOF/SOL/EOL/EOF and tracks frame/line state, line length and line count; flags protocol errors.
- Sits between the sensor data capture register and the frame-checker/statistics logic; keeps a toggle output for the existing checker.

Parameters:
- DATA_W, 12, pixel/data word width (>= 4).
- NZERO, 2, number of all-zero words after the all-ones word (1..15).
- CNT_W, 16, width of the line-length and line-count counters.
- SOF_CODE, 4'hA, code nibble (data_in[DATA_W-1 -: 4]) for start of frame.
- SOL_CODE, 4'h8, code nibble for start of line.
- EOL_CODE, 4'h9, code nibble for end of line.
- EOF_CODE, 4'hB, code nibble for end of frame.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  DATA_W  sensor data word.
- in_valid  in  1  data_in is valid this cycle; when low, all state and counters hold.
- toggle_out  out  1  inverts on every accepted valid sync code.
- sync_valid  out  1  one-cycle pulse, cycle after a valid code word.
- sync_type  out  2  0=SOF 1=SOL 2=EOL 3=EOF; holds last value.
- frame_active  out  1  high from SOF to EOF.
- line_active  out  1  high from SOL to EOL.
- line_len  out  CNT_W  payload words in the last completed line.
- line_count  out  CNT_W  EOLs completed since the last SOF.
- code_err  out  1  one-cycle pulse: preamble complete but code nibble unknown.
- proto_err  out  1  one-cycle pulse: code is illegal in the current frame/line state.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, zero counter=0, every output and internal counter=0. Reset mid-sequence discards the partial preamble.
- All transitions below happen only on cycles with in_valid=1.
- "ones" means data_in is all ones; "zeros" means data_in is all zeros.
- FSM:
  - IDLE: ones -> ONES.
  - ONES: zeros -> ZEROS with zcnt=1 (if NZERO=1, go to CODE instead); ones -> stay in ONES; anything else -> IDLE.
  - ZEROS: zeros -> zcnt++, and go to CODE when zcnt reaches NZERO; ones -> ONES; anything else -> IDLE.
  - CODE: decode data_in[DATA_W-1 -: 4].
    - Known code: sync_valid=1, sync_type set, toggle_out inverts (registered, one cycle of latency).
    - Unknown code: code_err=1.
    - Next state: ONES if data_in is ones, else IDLE.
- Frame/line update on a known code, in the same cycle as sync_valid:
  - SOL: if line_active, proto_err=1 and the line restarts. Then line_active=1, word counter wcnt=0.
  - EOL: if line_active: line_len=wcnt-(NZERO+1) (the preamble is excluded, floor at 0), line_count++ (saturating), line_active=0. If not line_active: proto_err=1, no other update.
  - SOF: if frame_active, proto_err=1. Then frame_active=1, line_count=0, line_active=0.
  - EOF: if !frame_active: proto_err=1, otherwise ignored. If line_active: proto_err=1, and frame_active and line_active both clear. Otherwise frame_active=0.
- wcnt increments on each in_valid cycle while line_active and state != CODE; it saturates at all-ones.
- If EOL arrives with NZERO+1 or fewer counted words, line_len=0.
- A code word of SOL/EOL is accepted regardless of frame_active (no proto_err for a line outside a frame).
- line_count and line_len hold their values after EOF until the next SOF/EOL.

Decomposition:
- Package sync_code_pkg holds:
  - the sync_type encoding constants (SYNC_SOF..SYNC_EOF);
  - the default code nibbles;
  - the FSM state encoding: IDLE, ONES, ZEROS, CODE.
- One sub-module is natural: preamble_fsm (the ONES/ZEROS/CODE detector). It outputs a code_strobe and the nibble.
- The top level does the frame/line tracking and counters.

Test Plan:
- Reset, then send 12-bit FFF,000,000,A00 -> sync_valid pulse, sync_type=0, frame_active=1, toggle_out=1.
- After SOF: SOL preamble+800, then 100 pixel words, then EOL preamble+900 -> line_len=100, line_count=1, line_active=0.
- FFF,FFF,000,000,800 -> SOL accepted (the repeated all-ones word restarts ONES). FFF,000,123 -> back to IDLE, no pulse. FFF,000,000,F00 -> code_err=1, toggle_out unchanged.
- in_valid low for 5 cycles between every word of a full SOF/SOL/EOL/EOF sequence -> results identical to the contiguous run.
- EOL without SOL -> proto_err=1, line_count unchanged. EOF while line_active -> proto_err=1, both active flags 0.
- rst_n low after FFF,000 -> all outputs 0. A following 000,800 yields no sync_valid.
